// File: rtl/carry_la_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package carry_la_pkg;

  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned CLA_BLK   = 8;

  function automatic int unsigned cla_nst(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/cla_group.sv
// BLK-bit combinational carry-lookahead group: sum, group carry-out and carry into the top bit.
module cla_group
  import carry_la_pkg::*;
#(
  parameter int unsigned BLK = CLA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK-1:0] w_g;
  logic [BLK-1:0] w_p;
  logic [BLK-1:0] w_c;
  logic           w_gg;
  logic           w_gp;

  assign w_g = a & b;
  assign w_p = a | b;

  // Each carry is a flat sum of products over generate/propagate terms, not a ripple.
  always_comb begin
    logic term;
    w_c  = '0;
    term = 1'b0;
    for (int unsigned i = 0; i < BLK; i++) begin
      term = cin;
      for (int unsigned j = 0; j < i; j++) term &= w_p[j];
      w_c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = w_g[j];
        for (int unsigned k = j + 1; k < i; k++) term &= w_p[k];
        w_c[i] |= term;
      end
    end
  end

  always_comb begin
    logic term;
    w_gg = 1'b0;
    term = 1'b0;
    w_gp = &w_p;
    for (int unsigned j = 0; j < BLK; j++) begin
      term = w_g[j];
      for (int unsigned k = j + 1; k < BLK; k++) term &= w_p[k];
      w_gg |= term;
    end
  end

  assign s     = a ^ b ^ w_c;
  assign cout  = w_gg | (w_gp & cin);
  assign c_msb = w_c[BLK-1];

endmodule

// File: rtl/carry_la_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BLK-bit group resolved per stage,
// valid/ready flow control with bubble collapse. Define CARRY_LA_OVF_EN for the ovf output.
module carry_la_pipe
  import carry_la_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned BLK   = CLA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CARRY_LA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NST = cla_nst(WIDTH, BLK);

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if (WIDTH % BLK != 0) begin : g_width_chk
    $error("carry_la_pipe: WIDTH must be a multiple of BLK");
  end

  stage_t           w_st [NST];
  logic [NST:0]     w_rdy;
  logic [NST-1:0]   w_gco;
  logic [NST-1:0]   w_cmsb;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  assign w_beff     = sub ? ~b : b;
  assign w_c0       = sub | cin;
  assign w_rdy[NST] = out_ready;
  assign in_ready   = w_rdy[0] && !rst;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    stage_t         r_st;
    stage_t         w_up;
    stage_t         w_nxt;
    logic [BLK-1:0] w_gs;

    // Stage 0's upstream is the port set shaped like a stage record; its carry field is c0.
    if (k == 0) begin : g_src_port
      always_comb begin
        w_up   = '0;
        w_up.v = in_valid;
        w_up.c = w_c0;
        w_up.a = a;
        w_up.b = w_beff;
      end
    end else begin : g_src_stage
      assign w_up = w_st[k-1];
    end

    cla_group #(.BLK(BLK)) u_grp (
      .a     (w_up.a[k*BLK +: BLK]),
      .b     (w_up.b[k*BLK +: BLK]),
      .cin   (w_up.c),
      .s     (w_gs),
      .cout  (w_gco[k]),
      .c_msb (w_cmsb[k])
    );

    always_comb begin
      w_nxt                    = w_up;
      w_nxt.sum[k*BLK +: BLK]  = w_gs;
      w_nxt.c                  = w_gco[k];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_st <= '0;
      end else if (w_rdy[k]) begin
        r_st <= w_nxt;
      end
    end

    assign w_rdy[k] = !r_st.v || w_rdy[k+1];
    assign w_st[k]  = r_st;
  end

  assign out_valid = w_st[NST-1].v;
  assign s         = w_st[NST-1].sum;
  assign cout      = w_st[NST-1].c;

`ifdef CARRY_LA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_rdy[NST-1]) begin
      r_ovf <= w_cmsb[NST-1] ^ w_gco[NST-1];
    end
  end

  assign ovf = r_ovf;
`endif

  logic w_unused;
  assign w_unused = ^{w_cmsb, w_st[NST-1].a, w_st[NST-1].b};

endmodule
